// File: rtl/axi_excl_pkg.sv
// rtl/axi_excl_pkg.sv - shared types for the exclusive-access AXI RAM
package axi_excl_pkg;

    localparam int RESV_ADDR_W  = 32;
    localparam int RESV_TIMER_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10
    } resp_t;

    typedef struct packed {
        logic                    valid;
        logic [RESV_ADDR_W-1:0]  addr;
        logic [RESV_TIMER_W-1:0] timer;
    } resv_entry_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wstate_t;

endpackage

// File: rtl/excl_monitor.sv
// rtl/excl_monitor.sv - per-core LR/SC reservation table with expiry timers
module excl_monitor #(
    parameter int NUM_CORES       = 2,
    parameter int MASTER_ID_WIDTH = 1,
    parameter int WORD_AW         = 8,
    parameter int RESV_TIMEOUT    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       set_i,
    input  logic [MASTER_ID_WIDTH-1:0] set_id_i,
    input  logic [WORD_AW-1:0]         set_addr_i,
    input  logic                       clr_all_i,
    input  logic [WORD_AW-1:0]         clr_all_addr_i,
    input  logic                       clr_own_i,
    input  logic [MASTER_ID_WIDTH-1:0] clr_own_id_i,
    input  logic [MASTER_ID_WIDTH-1:0] chk_id_i,
    input  logic [WORD_AW-1:0]         chk_addr_i,
    output logic                       chk_match_o,
    output logic [NUM_CORES-1:0]       resv_valid_o
);
    import axi_excl_pkg::*;

    resv_entry_t entries_q [NUM_CORES];
    resv_entry_t entries_d [NUM_CORES];

    // Order matters: expiry, then clears, then a new LR overrides its own entry.
    always_comb begin
        chk_match_o  = 1'b0;
        resv_valid_o = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            entries_d[k] = entries_q[k];
            if (RESV_TIMEOUT > 0 && entries_q[k].valid) begin
                entries_d[k].timer = entries_q[k].timer - 1'b1;
                if (entries_q[k].timer <= 1) begin
                    entries_d[k].valid = 1'b0;
                end
            end
            if (clr_all_i && entries_q[k].valid &&
                entries_q[k].addr == RESV_ADDR_W'(clr_all_addr_i)) begin
                entries_d[k].valid = 1'b0;
            end
            if (clr_own_i && clr_own_id_i == MASTER_ID_WIDTH'(k)) begin
                entries_d[k].valid = 1'b0;
            end
            if (set_i && set_id_i == MASTER_ID_WIDTH'(k)) begin
                entries_d[k].valid = 1'b1;
                entries_d[k].addr  = RESV_ADDR_W'(set_addr_i);
                entries_d[k].timer = RESV_TIMER_W'(RESV_TIMEOUT);
            end
            if (chk_id_i == MASTER_ID_WIDTH'(k) && entries_q[k].valid &&
                entries_q[k].addr == RESV_ADDR_W'(chk_addr_i)) begin
                chk_match_o = 1'b1;
            end
            resv_valid_o[k] = entries_q[k].valid;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                entries_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                entries_q[k] <= entries_d[k];
            end
        end
    end

endmodule

// File: rtl/axi_excl_ram.sv
// rtl/axi_excl_ram.sv - single-beat AXI RAM with LR/SC exclusive monitor
module axi_excl_ram #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int NUM_CORES       = 2,
    parameter int MASTER_ID_WIDTH = $clog2(NUM_CORES),
    parameter int RESV_TIMEOUT    = 16
) (
    input  logic                       axi_aclk,
    input  logic                       axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]      axi_awaddr,
    input  logic [2:0]                 axi_awprot,
    input  logic                       axi_awvalid,
    input  logic [MASTER_ID_WIDTH-1:0] axi_awid,
    input  logic                       axi_awlock,
    output logic                       axi_awready,
    input  logic [DATA_WIDTH-1:0]      axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]    axi_wstrb,
    input  logic                       axi_wvalid,
    output logic                       axi_wready,
    output logic [1:0]                 axi_bresp,
    output logic                       axi_bvalid,
    output logic [MASTER_ID_WIDTH-1:0] axi_bid,
    input  logic                       axi_bready,
    input  logic [ADDR_WIDTH-1:0]      axi_araddr,
    input  logic [2:0]                 axi_arprot,
    input  logic                       axi_arvalid,
    input  logic [MASTER_ID_WIDTH-1:0] axi_arid,
    input  logic                       axi_arlock,
    output logic                       axi_arready,
    output logic [DATA_WIDTH-1:0]      axi_rdata,
    output logic [1:0]                 axi_rresp,
    output logic                       axi_rvalid,
    output logic [MASTER_ID_WIDTH-1:0] axi_rid,
    input  logic                       axi_rready,
    output logic [NUM_CORES-1:0]       resv_valid
);
    import axi_excl_pkg::*;

    localparam int NB      = DATA_WIDTH / 8;
    localparam int OFF_W   = $clog2(NB);
    localparam int WORD_AW = ADDR_WIDTH - OFF_W;
    localparam int DEPTH   = 2 ** WORD_AW;
    localparam logic [ADDR_WIDTH-1:0]    OFF_MASK = ADDR_WIDTH'(NB - 1);
    localparam logic [MASTER_ID_WIDTH:0] CORES_L  = (MASTER_ID_WIDTH + 1)'(NUM_CORES);

    function automatic logic misaligned(input logic [ADDR_WIDTH-1:0] a);
        return (a & OFF_MASK) != '0;
    endfunction

    function automatic logic id_oob(input logic [MASTER_ID_WIDTH-1:0] id);
        return {1'b0, id} >= CORES_L;
    endfunction

    logic unused_prot;
    assign unused_prot = ^{axi_awprot, axi_arprot};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Holds the handshake outputs low until the first edge after reset release.
    logic rst_done_q;

    wstate_t                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]      aw_addr_q, aw_addr_d;
    logic [MASTER_ID_WIDTH-1:0] aw_id_q, aw_id_d;
    logic                       aw_lock_q, aw_lock_d;
    logic [DATA_WIDTH-1:0]      w_data_q, w_data_d;
    logic [NB-1:0]              w_strb_q, w_strb_d;
    resp_t                      bresp_q, bresp_d;
    logic [MASTER_ID_WIDTH-1:0] bid_q, bid_d;

    logic                       rvalid_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    resp_t                      rresp_q;
    logic [MASTER_ID_WIDTH-1:0] rid_q;

    logic                       aw_hs, w_hs, ar_hs, w_exec;
    logic [ADDR_WIDTH-1:0]      w_eff_addr;
    logic [MASTER_ID_WIDTH-1:0] w_eff_id;
    logic                       w_eff_lock;
    logic [DATA_WIDTH-1:0]      w_eff_data;
    logic [NB-1:0]              w_eff_strb;
    logic [WORD_AW-1:0]         w_word, r_word;
    logic                       w_excl_err, r_excl_err, sc_match;
    logic                       mem_we, clr_all, clr_own, lr_set;

    assign axi_awready = rst_done_q && (state_q == W_IDLE || state_q == W_DATA);
    assign axi_wready  = rst_done_q && (state_q == W_IDLE || state_q == W_ADDR);
    assign axi_arready = rst_done_q && (!rvalid_q || axi_rready);
    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;
    assign ar_hs = axi_arvalid && axi_arready;

    always_comb begin
        state_d    = state_q;
        aw_addr_d  = aw_addr_q;
        aw_id_d    = aw_id_q;
        aw_lock_d  = aw_lock_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        w_exec     = 1'b0;
        w_eff_addr = aw_addr_q;
        w_eff_id   = aw_id_q;
        w_eff_lock = aw_lock_q;
        w_eff_data = w_data_q;
        w_eff_strb = w_strb_q;
        if (state_q == W_IDLE || state_q == W_DATA) begin
            w_eff_addr = axi_awaddr;
            w_eff_id   = axi_awid;
            w_eff_lock = axi_awlock;
        end
        if (state_q == W_IDLE || state_q == W_ADDR) begin
            w_eff_data = axi_wdata;
            w_eff_strb = axi_wstrb;
        end
        unique case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_exec = 1'b1;
                end else if (aw_hs) begin
                    aw_addr_d = axi_awaddr;
                    aw_id_d   = axi_awid;
                    aw_lock_d = axi_awlock;
                    state_d   = W_ADDR;
                end else if (w_hs) begin
                    w_data_d = axi_wdata;
                    w_strb_d = axi_wstrb;
                    state_d  = W_DATA;
                end
            end
            W_ADDR:  w_exec = w_hs;
            W_DATA:  w_exec = aw_hs;
            W_RESP:  if (axi_bready) state_d = W_IDLE;
            default: state_d = W_IDLE;
        endcase
        if (w_exec) begin
            state_d = W_RESP;
        end
    end

    assign w_word     = w_eff_addr[ADDR_WIDTH-1:OFF_W];
    assign r_word     = axi_araddr[ADDR_WIDTH-1:OFF_W];
    assign w_excl_err = w_eff_lock && (misaligned(w_eff_addr) || id_oob(w_eff_id));
    assign r_excl_err = axi_arlock && (misaligned(axi_araddr) || id_oob(axi_arid));
    assign lr_set     = ar_hs && axi_arlock && !r_excl_err;

    // A failed SC writes nothing and only drops the issuer's own reservation.
    always_comb begin
        mem_we  = w_exec && (!w_eff_lock || (!w_excl_err && sc_match));
        clr_all = mem_we;
        clr_own = w_exec && w_eff_lock && !w_excl_err && !sc_match;
        bresp_d = bresp_q;
        bid_d   = bid_q;
        if (w_exec) begin
            bid_d = w_eff_id;
            if (w_excl_err) begin
                bresp_d = SLVERR;
            end else if (w_eff_lock && sc_match) begin
                bresp_d = EXOKAY;
            end else begin
                bresp_d = OKAY;
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rst_done_q <= 1'b0;
            state_q    <= W_IDLE;
            aw_addr_q  <= '0;
            aw_id_q    <= '0;
            aw_lock_q  <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= OKAY;
            bid_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
            rid_q      <= '0;
        end else begin
            rst_done_q <= 1'b1;
            state_q    <= state_d;
            aw_addr_q  <= aw_addr_d;
            aw_id_q    <= aw_id_d;
            aw_lock_q  <= aw_lock_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bresp_q    <= bresp_d;
            bid_q      <= bid_d;
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= mem_q[r_word];
                rid_q    <= axi_arid;
                rresp_q  <= r_excl_err ? SLVERR : (axi_arlock ? EXOKAY : OKAY);
            end else if (axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Memory has no reset; a same-cycle read above samples the pre-write word.
    always_ff @(posedge axi_aclk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (w_eff_strb[b]) begin
                    mem_q[w_word][8*b +: 8] <= w_eff_data[8*b +: 8];
                end
            end
        end
    end

    assign axi_bvalid = (state_q == W_RESP);
    assign axi_bresp  = bresp_q;
    assign axi_bid    = bid_q;
    assign axi_rvalid = rvalid_q;
    assign axi_rdata  = rdata_q;
    assign axi_rresp  = rresp_q;
    assign axi_rid    = rid_q;

    excl_monitor #(
        .NUM_CORES       (NUM_CORES),
        .MASTER_ID_WIDTH (MASTER_ID_WIDTH),
        .WORD_AW         (WORD_AW),
        .RESV_TIMEOUT    (RESV_TIMEOUT)
    ) u_excl_monitor (
        .clk_i          (axi_aclk),
        .rst_ni         (axi_aresetn),
        .set_i          (lr_set),
        .set_id_i       (axi_arid),
        .set_addr_i     (r_word),
        .clr_all_i      (clr_all),
        .clr_all_addr_i (w_word),
        .clr_own_i      (clr_own),
        .clr_own_id_i   (w_eff_id),
        .chk_id_i       (w_eff_id),
        .chk_addr_i     (w_word),
        .chk_match_o    (sc_match),
        .resv_valid_o   (resv_valid)
    );

endmodule

// File: doc/axi_excl_ram.md
AXI_EXCL_RAM -- requirements
Module: axi_excl_ram

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which is the data bus width in bits (a multiple of 8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, which is the byte address width; memory depth is 2**ADDR_WIDTH/(DATA_WIDTH/8) words.
REQ-003 The block SHALL have parameter NUM_CORES, default 2, which is the number of masters, one reservation entry each.
REQ-004 The block SHALL have parameter MASTER_ID_WIDTH, default $clog2(NUM_CORES), which is the ID width.
REQ-005 The block SHALL have parameter RESV_TIMEOUT, default 16, which is the reservation lifetime in cycles; 0 disables expiry.
REQ-006 Ports (clock and reset first):
- axi_aclk  in  1  clock; single clock domain.
- axi_aresetn  in  1  asynchronous active-low reset.
- axi_awaddr/awprot/awvalid/awid/awlock  in  ADDR_WIDTH/3/1/MASTER_ID_WIDTH/1  write address channel; awlock=1 marks an exclusive write (SC).
- axi_awready  out  1  write address accepted.
- axi_wdata/wstrb/wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1  write data channel.
- axi_wready  out  1  write data accepted.
- axi_bresp/bvalid/bid  out  2/1/MASTER_ID_WIDTH  write response.
- axi_bready  in  1  write response accepted by the master.
- axi_araddr/arprot/arvalid/arid/arlock  in  ADDR_WIDTH/3/1/MASTER_ID_WIDTH/1  read address channel; arlock=1 marks an exclusive read (LR).
- axi_arready  out  1  read address accepted.
- axi_rdata/rresp/rvalid/rid  out  DATA_WIDTH/2/1/MASTER_ID_WIDTH  read data.
- axi_rready  in  1  read data accepted by the master.
- resv_valid  out  NUM_CORES  per-core reservation status.

Function
REQ-007 All transfers SHALL be single-beat, with word-aligned addressing using awaddr/araddr[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)]; prot inputs are ignored.
REQ-008 The write FSM SHALL have states W_IDLE, W_ADDR (AW held, awaiting W), W_DATA (W held, awaiting AW) and W_RESP.
REQ-009 In W_IDLE, awready=wready=1; AW and W may handshake in the same cycle or in either order.
REQ-010 The write SHALL execute in the cycle in which both AW and W are held, followed by W_RESP with bvalid=1 in the next cycle.
REQ-011 bvalid, bresp and bid SHALL be held stable until bready; awready=wready=0 in W_RESP; the FSM returns to W_IDLE on the B handshake.
REQ-012 The read path SHALL drive arready=!rvalid||rready.
REQ-013 rvalid SHALL assert 1 cycle after the AR handshake, with rdata, rresp and rid held until rready; back-to-back reads SHALL sustain 1 per cycle when rready=1.
REQ-014 RAM writes SHALL honour wstrb per byte.
REQ-015 A read and a write to the same word handshaking in the same cycle SHALL return the old data (read-before-write).
REQ-016 A normal read (arlock=0) SHALL return rresp=OKAY(00).
REQ-017 An LR (arlock=1, aligned) SHALL set entry[arid]={valid, word addr, timer=RESV_TIMEOUT} and return rresp=EXOKAY(01).
REQ-018 An SC whose entry[awid] is valid with matching word address SHALL write memory, return bresp=EXOKAY, and clear every entry holding that address, including its own.
REQ-019 An SC without a matching valid reservation SHALL NOT write memory and SHALL return bresp=OKAY(00); entry[awid] SHALL be cleared.
REQ-020 A normal write SHALL write memory, return OKAY, and clear every entry holding that address.
REQ-021 An exclusive access with addr[1:0]!=0 (for DATA_WIDTH=32) SHALL return SLVERR(10), leave memory unchanged and leave reservations unchanged.
REQ-022 Any ID >= NUM_CORES SHALL return SLVERR on exclusive accesses and be treated as a normal access otherwise.
REQ-023 When RESV_TIMEOUT>0, each valid entry's timer SHALL decrement every cycle and the entry SHALL clear when the timer reaches 0.
REQ-024 A re-issued LR SHALL reload the timer.
REQ-025 On a same-cycle LR set and write clear of the same entry, the set SHALL win; clears of other entries SHALL still apply.
REQ-026 resv_valid[k] SHALL equal entry[k].valid, registered.

Reset
REQ-027 On axi_aresetn=0 (asynchronous), the write FSM SHALL go to W_IDLE, and bvalid, rvalid, and all entries/timers SHALL be 0, with bresp, rresp, bid, rid and rdata =0.
REQ-028 In-flight transactions SHALL be dropped on reset; memory contents are not reset.
REQ-029 The handshake outputs awready, wready and arready SHALL be 0 during reset and go to 1 the cycle after release.

Structure
REQ-030 Package axi_excl_pkg SHALL hold: the resp_t enum (OKAY=00, EXOKAY=01, SLVERR=10), the resv_entry_t struct (valid, addr, timer) and the write FSM state enum.
REQ-031 The reservation table, timers and match/clear logic SHALL be a sub-module, excl_monitor.
REQ-032 The RAM array and AXI FSMs SHALL remain in the top level.

Verification
REQ-033 The bench SHALL write 0xDEADBEEF at 0x010 with wstrb=F, then read 0x010, and check rdata=0xDEADBEEF, rresp=00, bresp=00.
REQ-034 The bench SHALL have core0 issue an LR at 0x020, then an SC of 0x1 at 0x020 within 16 cycles, and check rresp=01, bresp=01, memory=0x1 and resv_valid=00.
REQ-035 The bench SHALL have core0 and core1 both LR at 0x020; core1 SCs (bresp=01), then core0 SCs 0x5, and check bresp=00 and memory unchanged.
REQ-036 The bench SHALL have core0 LR at 0x030, wait 17 cycles, then SC, and check bresp=00, no write, and that resv_valid[0] dropped at cycle 16.
REQ-037 The bench SHALL hold bready=0 for 5 cycles and check bvalid/bresp stable and awready=wready=0; an exclusive write to 0x022 SHALL return bresp=10.
REQ-038 The bench SHALL assert axi_aresetn=0 during W_RESP and check bvalid=0 and resv_valid=0 immediately, asynchronously.
